// File: rtl/uart_transmitter.sv
// uart_transmitter: asynchronous serial transmitter.
// Frame: start bit, 8 data bits LSB first, optional even parity bit, stop bit.
// Every bit lasts 16 ticks of D clocks, where D is picked by baud_select.
// Build option: define UART_TX_PARITY_EN to insert the even-parity bit (11-bit frames);
// when undefined the frame is 10 bits long and DATA goes straight to STOP.
//
// state  | meaning
// IDLE   | line high, waiting for an accepted write
// START  | driving the start bit (0)
// DATA   | driving data_q[bit_idx_q], bit index 0..7
// PARITY | driving ^data_q (only with UART_TX_PARITY_EN)
// STOP   | driving the stop bit (1); Tx_DONE pulses when it ends
module uart_transmitter #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Rounded clocks-per-tick for a 16x oversampled baud rate; shared table with the receiver.
  function automatic logic [13:0] div_for(input int baud);
    return 14'((CLK_HZ + 8 * baud) / (16 * baud));
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  sel_q, sel_d;
  logic [13:0] div_cnt_q, div_cnt_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [13:0] div_last;
  logic        bit_end;

  // Terminal count of the divider for the rate latched at write acceptance.
  always_comb begin
    case (sel_q)
      3'd0:    div_last = div_for(300) - 14'd1;
      3'd1:    div_last = div_for(1200) - 14'd1;
      3'd2:    div_last = div_for(4800) - 14'd1;
      3'd3:    div_last = div_for(9600) - 14'd1;
      3'd4:    div_last = div_for(19200) - 14'd1;
      3'd5:    div_last = div_for(38400) - 14'd1;
      3'd6:    div_last = div_for(57600) - 14'd1;
      default: div_last = div_for(115200) - 14'd1;
    endcase
  end

  // Next-state, bit timing and next registered output values.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    sel_d     = sel_q;
    div_cnt_d = div_cnt_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_end   = 1'b0;

    if (state_q == IDLE) begin
      txd_d  = 1'b1;
      busy_d = 1'b0;
      if (Tx_WR && Tx_EN && !busy_q) begin
        data_d    = Tx_DATA;
        sel_d     = baud_select;
        div_cnt_d = '0;
        tick_d    = '0;
        bit_idx_d = '0;
        state_d   = START;
        txd_d     = 1'b0;
        busy_d    = 1'b1;
      end
    end else begin
      if (div_cnt_q == div_last) begin
        div_cnt_d = '0;
        tick_d    = tick_q + 4'd1;
        bit_end   = (tick_q == 4'd15);
      end else begin
        div_cnt_d = div_cnt_q + 14'd1;
      end

      // Outputs change only on bit-period boundaries.
      if (bit_end) begin
        case (state_q)
          START: begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
            txd_d     = data_q[0];
          end
          DATA: begin
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              txd_d   = ^data_q;
`else
              state_d = STOP;
              txd_d   = 1'b1;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              txd_d     = data_q[bit_idx_q + 3'd1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state_d = STOP;
            txd_d   = 1'b1;
          end
`endif
          STOP: begin
            state_d = IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
        endcase
      end
    end
  end

  // State and output registers; reset idles the line immediately and drops any frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      sel_q     <= '0;
      div_cnt_q <= '0;
      tick_q    <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;
  assign Tx_DONE = done_q;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmitter stage feeding the UART receiver's RxD line. Accepts a byte from the host over a single-cycle write strobe and serialises it as an asynchronous frame: start bit, 8 data bits LSB first, even parity bit, stop bit. Bit timing comes from a baud-rate divider selected by `baud_select`. The divider table is shared with the receiver so that both ends agree on the rate. The block sits between the host register interface and the physical TxD pin, or the receiver's RxD in loopback benches.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency. The divider table below is fixed for this value.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Tx_EN`  in  1  transmitter enable; writes are refused while low
- `Tx_WR`  in  1  write strobe, sampled each rising edge
- `Tx_DATA`  in  8  byte to send, sampled when a write is accepted
- `baud_select`  in  3  rate select, latched when a write is accepted
- `TxD`  out  1  serial line, idles high
- `Tx_BUSY`  out  1  high from write acceptance until the stop bit ends
- `Tx_DONE`  out  1  one-cycle pulse when a frame completes

## Operation
- **Reset values:** TxD=1, Tx_BUSY=0, Tx_DONE=0, state=IDLE, all counters=0.
- **Divider D by `baud_select` 0..7:** 10417, 2604, 651, 326, 163, 81, 54, 27. These correspond to 300, 1200, 4800, 9600, 19200, 38400, 57600 and 115200 baud.
- **Bit period:** 16 ticks of D clocks each, i.e. 16·D clocks. For select 3 this is 5216 clocks (104320 ns).
- **Write acceptance:** `Tx_WR`=1, `Tx_EN`=1 and `Tx_BUSY`=0 at an edge. On that edge the block:
  - latches `Tx_DATA` and `baud_select`;
  - clears the divider and tick counters;
  - enters START.
- **Refused writes:** `Tx_WR` while busy or while `Tx_EN`=0 is ignored. Nothing is queued.
- **States:** IDLE → START → DATA (bit index 0..7) → PARITY → STOP → IDLE.
  - Each non-IDLE state drives TxD for exactly one bit period.
  - START drives 0.
  - DATA drives `data[i]`.
  - PARITY drives `^data` (even parity).
  - STOP drives 1.
- **Width rules:**
  - Divider counter: 14 bits, wraps at D−1.
  - Tick counter: 4 bits, wraps at 15.
  - Bit index: 3 bits.
- **Mid-frame `Tx_EN` deassert:** the current frame completes normally. Only new writes are blocked.
- **Mid-frame `baud_select` change:** no effect until the next accepted write.
- **Frame end:** at the end of STOP, `Tx_DONE` pulses and `Tx_BUSY` falls on the same edge.
- **Back-to-back frames:** a write in the cycle where `Tx_BUSY` is already 0 is accepted. The new frame's start bit then follows the previous stop bit with no extra idle time.
- **Reset assertion mid-frame:** TxD=1 and Tx_BUSY=0 immediately (asynchronously). The frame is lost.

## Timing
- **Write latency:** write accepted at edge k, so TxD=0 and Tx_BUSY=1 from edge k (registered outputs, visible after k).
- **Start bit:** TxD transitions only on bit-period boundaries, at edges k + n·16·D for n=1..10.
- **Frame length:** 11·16·D clocks with parity. Select 3 gives 57376 clocks.
- **Completion:** `Tx_DONE` high for the single cycle after edge k + 11·16·D. `Tx_BUSY` is low from that same edge.
- **Outputs:** all are registered and glitch-free.

## Configuration
- **`UART_TX_PARITY_EN` defined:** frame includes the PARITY state. 11 bits per frame.
- **`UART_TX_PARITY_EN` undefined:** PARITY state is removed and DATA goes straight to STOP. 10 bits per frame, frame length 10·16·D clocks, `Tx_DONE` shifted accordingly. All other behaviour is identical.

## Test plan
- Reset low for 50 ns, then release → TxD=1, Tx_BUSY=0, Tx_DONE=0 throughout reset and idle.
- Select 3, write 8'hA5 → TxD sequence 0,1,0,1,0,0,1,0,1,0(parity),1. Each bit lasts 5216 clocks. Tx_DONE pulses 57376 clocks after acceptance.
- Select 7, write 8'hFF, then a second write during busy → single frame 0,1×8,0,1 at 432 clocks per bit. The second write is ignored and Tx_BUSY falls once.
- Loopback into the receiver at select 3, bytes 8'h00, 8'h55, 8'hFF back-to-back on Tx_DONE → receiver reports matching Rx_DATA with Rx_VALID and no Rx_PERROR or Rx_FERROR.
- Assert reset during DATA bit 4 → TxD=1 and Tx_BUSY=0 asynchronously. A write after release starts a fresh start bit.
- Tx_EN=0 with write 8'h3C → no frame, TxD stays 1. Deasserting Tx_EN mid-frame → the frame completes and Tx_DONE pulses.
